gshare_branch_predictor: RTL and testbench
==========================================

Name: gshare_branch_predictor

Overview:
- Parametrised, two-lane successor to the superscalar BHT/BTB predictor.
- Gshare-indexed 2-bit pattern history table (PHT) plus a tagged direct-mapped BTB.
- Speculative global history register (GHR), repaired on mispredict.
- Sequential init sweep instead of a single-cycle array reset.
- Sits between fetch (lookup lanes 0/1, lane 0 older) and memory-stage branch resolution (update lanes 0/1).

Parameters:
- PC_W, 9, PC width (word addresses).
- IDX_W, 6, log2 PHT/BTB depth.
- HIST_W, 6, GHR width; must be <= IDX_W.
- TAG_W, 3, BTB tag width; PC_W >= IDX_W+TAG_W.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- busy_o  out  1  init sweep in progress
- fetch_valid_i  in  1  lookup results are consumed this cycle
- pc0_i, pc1_i  in  PC_W  lookup PCs
- pred_taken0_o, pred_taken1_o  out  1  predicted taken
- pred_target0_o, pred_target1_o  out  PC_W  predicted next PC
- pred_hist0_o, pred_hist1_o  out  HIST_W  history used to index; carried down the pipe
- upd_valid0_i, upd_valid1_i  in  1  resolved branch present
- upd_pc0_i, upd_pc1_i  in  PC_W  branch PC
- upd_hist0_i, upd_hist1_i  in  HIST_W  history checkpoint returned from pred_hist*_o
- upd_taken0_i, upd_taken1_i  in  1  actual direction
- upd_target0_i, upd_target1_i  in  PC_W  actual target
- upd_mispred0_i, upd_mispred1_i  in  1  prediction was wrong

Behaviour:
- Reset (asynchronous, active-high):
  - GHR=0, init counter=0, busy_o=1.
  - All pred outputs follow the busy rules below.
- Init sweep:
  - One entry per cycle: PHT[i]=2'b01, BTB_valid[i]=0.
  - Lasts 2^IDX_W cycles; busy_o falls the cycle after entry 2^IDX_W-1 is written.
  - Reset asserted mid-sweep restarts it at 0.
- While busy_o=1:
  - pred_taken*=0, pred_target*=pc+1, pred_hist*=0.
  - Updates are ignored; GHR holds 0.
- Lookup (combinational, asynchronous array read):
  - Lane 0 PHT index = pc0[IDX_W-1:0] XOR zero-extended GHR.
  - BTB index = pc[IDX_W-1:0]; tag = pc[IDX_W+TAG_W-1:IDX_W].
  - hit = valid && tag match.
  - pred_taken = hit && PHT[idx][1].
  - pred_target = pred_taken ? BTB_target : pc+1, modulo 2^PC_W.
- Lane 1 history:
  - Lane 1 uses h1 = hit0 ? {GHR[HIST_W-2:0], pred_taken0} : GHR.
  - If pred_taken0=1, lane 1 is squashed: pred_taken1=0, target pc1+1, no GHR contribution.
- Speculative GHR, when fetch_valid_i && !busy_o:
  - Shift in pred_taken of each unsquashed lane whose BTB hit, lane 0 first.
  - Up to 2 bits shift per cycle.
- Repair:
  - upd_mispred0 => GHR <= {upd_hist0[HIST_W-2:0], upd_taken0}.
  - Otherwise upd_mispred1 => same from lane 1.
  - Repair overrides the speculative shift in the same cycle.
- PHT update:
  - Counter at upd_pc[IDX_W-1:0] XOR upd_hist saturates toward upd_taken (00..11).
  - Both lanes at the same index: result = step(step(c, taken0), taken1).
- BTB update:
  - Write only when taken: target, tag, valid=1.
  - Not-taken never allocates or invalidates.
  - Same-index collision: lane 1 write wins.
- Update visibility: all updates are visible to lookups the following cycle; there is no same-cycle bypass.

Optional Feature:
- Macro: BPU_STATS_EN.
- With it defined:
  - Adds outputs br_count_o[15:0] and mispred_count_o[15:0], both saturating at 16'hFFFF.
  - Increment by the number of valid updates (0-2) and the number of valid mispredicts per cycle.
  - Cleared by reset and held at 0 during the init sweep.
- Without it: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Deassert reset -> busy_o high for exactly 64 cycles, then low; every lookup during busy returns taken=0, target=pc+1.
- Update lane 0, pc=0x012, hist=0, taken, target=0x040, twice; then lookup 0x012 with GHR=0 -> pred_taken0=1, target=0x040.
- Same index, lane 0 taken and lane 1 not-taken in one cycle from 2'b01 -> counter stays 01.
- Lookup lane 0 predicted taken with a lane 1 BTB hit -> pred_taken1=0, GHR gains exactly one bit (1).
- Speculative GHR=6'b101101, upd_mispred0 with hist=6'b000011 and taken=0 -> next-cycle GHR=6'b000110, ignoring a concurrent fetch shift.
- Tag alias: train pc=0x005 taken, then look up pc=0x045 (same index, different tag) -> miss, target=0x046.

Source files
------------

// File: rtl/gshare_branch_predictor.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | gshare_branch_predictor: two-lane gshare PHT + tagged BTB, speculative GHR |
// | Optional statistics counters enabled with macro BPU_STATS_EN.              |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module gshare_branch_predictor #(
  parameter int PC_W   = 9,
  parameter int IDX_W  = 6,
  parameter int HIST_W = 6,
  parameter int TAG_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  output logic              busy_o,
  input  logic              fetch_valid_i,
  input  logic [PC_W-1:0]   pc0_i,
  input  logic [PC_W-1:0]   pc1_i,
  output logic              pred_taken0_o,
  output logic              pred_taken1_o,
  output logic [PC_W-1:0]   pred_target0_o,
  output logic [PC_W-1:0]   pred_target1_o,
  output logic [HIST_W-1:0] pred_hist0_o,
  output logic [HIST_W-1:0] pred_hist1_o,
  input  logic              upd_valid0_i,
  input  logic              upd_valid1_i,
  input  logic [PC_W-1:0]   upd_pc0_i,
  input  logic [PC_W-1:0]   upd_pc1_i,
  input  logic [HIST_W-1:0] upd_hist0_i,
  input  logic [HIST_W-1:0] upd_hist1_i,
  input  logic              upd_taken0_i,
  input  logic              upd_taken1_i,
  input  logic [PC_W-1:0]   upd_target0_i,
  input  logic [PC_W-1:0]   upd_target1_i,
  input  logic              upd_mispred0_i,
  input  logic              upd_mispred1_i
`ifdef BPU_STATS_EN
  ,
  output logic [15:0]       br_count_o,
  output logic [15:0]       mispred_count_o
`endif
);

  localparam int DEPTH = 1 << IDX_W;

  logic [1:0]        pht        [DEPTH];
  logic [DEPTH-1:0]  btb_valid;
  logic [TAG_W-1:0]  btb_tag    [DEPTH];
  logic [PC_W-1:0]   btb_target [DEPTH];
  logic [HIST_W-1:0] ghr;
  logic [IDX_W-1:0]  init_idx;

  function automatic logic [1:0] step(input logic [1:0] c, input logic t);
    if (t) return (c == 2'b11) ? c : c + 2'b01;
    else   return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  logic [IDX_W-1:0]  bidx0, bidx1, pidx0, pidx1;
  logic              hit0, hit1, take0, take1;
  logic [HIST_W-1:0] h1, ghr_spec;

  assign bidx0 = pc0_i[IDX_W-1:0];
  assign bidx1 = pc1_i[IDX_W-1:0];
  assign pidx0 = bidx0 ^ IDX_W'(ghr);
  assign hit0  = btb_valid[bidx0] && (btb_tag[bidx0] == pc0_i[IDX_W+TAG_W-1:IDX_W]);
  assign take0 = !busy_o && hit0 && pht[pidx0][1];

  // Lane 1 sees lane 0's predicted outcome folded into its history
  assign h1    = hit0 ? {ghr[HIST_W-2:0], take0} : ghr;
  assign pidx1 = bidx1 ^ IDX_W'(h1);
  assign hit1  = btb_valid[bidx1] && (btb_tag[bidx1] == pc1_i[IDX_W+TAG_W-1:IDX_W]);
  assign take1 = !busy_o && !take0 && hit1 && pht[pidx1][1];

  assign ghr_spec = (hit1 && !take0) ? {h1[HIST_W-2:0], take1} : h1;

  assign pred_taken0_o  = take0;
  assign pred_taken1_o  = take1;
  assign pred_target0_o = take0 ? btb_target[bidx0] : pc0_i + PC_W'(1);
  assign pred_target1_o = take1 ? btb_target[bidx1] : pc1_i + PC_W'(1);
  assign pred_hist0_o   = busy_o ? '0 : ghr;
  assign pred_hist1_o   = busy_o ? '0 : h1;

  logic [IDX_W-1:0] uidx0, uidx1, ubidx0, ubidx1;
  logic             mis0, mis1;

  assign ubidx0 = upd_pc0_i[IDX_W-1:0];
  assign ubidx1 = upd_pc1_i[IDX_W-1:0];
  assign uidx0  = ubidx0 ^ IDX_W'(upd_hist0_i);
  assign uidx1  = ubidx1 ^ IDX_W'(upd_hist1_i);
  assign mis0   = upd_valid0_i && upd_mispred0_i;
  assign mis1   = upd_valid1_i && upd_mispred1_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ghr      <= '0;
      init_idx <= '0;
      busy_o   <= 1'b1;
    end else if (busy_o) begin
      init_idx <= init_idx + IDX_W'(1);
      if (init_idx == IDX_W'(DEPTH - 1)) busy_o <= 1'b0;
    end else if (mis0) begin
      ghr <= {upd_hist0_i[HIST_W-2:0], upd_taken0_i};
    end else if (mis1) begin
      ghr <= {upd_hist1_i[HIST_W-2:0], upd_taken1_i};
    end else if (fetch_valid_i) begin
      ghr <= ghr_spec;
    end
  end

  // Arrays carry no reset; the init sweep clears them one entry per cycle
  always_ff @(posedge clk) begin
    if (busy_o) begin
      pht[init_idx]       <= 2'b01;
      btb_valid[init_idx] <= 1'b0;
    end else begin
      if (upd_valid0_i && upd_valid1_i && (uidx0 == uidx1)) begin
        pht[uidx0] <= step(step(pht[uidx0], upd_taken0_i), upd_taken1_i);
      end else begin
        if (upd_valid0_i) pht[uidx0] <= step(pht[uidx0], upd_taken0_i);
        if (upd_valid1_i) pht[uidx1] <= step(pht[uidx1], upd_taken1_i);
      end
      if (upd_valid0_i && upd_taken0_i) begin
        btb_valid[ubidx0]  <= 1'b1;
        btb_tag[ubidx0]    <= upd_pc0_i[IDX_W+TAG_W-1:IDX_W];
        btb_target[ubidx0] <= upd_target0_i;
      end
      if (upd_valid1_i && upd_taken1_i) begin
        btb_valid[ubidx1]  <= 1'b1;
        btb_tag[ubidx1]    <= upd_pc1_i[IDX_W+TAG_W-1:IDX_W];
        btb_target[ubidx1] <= upd_target1_i;
      end
    end
  end

`ifdef BPU_STATS_EN
  function automatic logic [15:0] sat_add(input logic [15:0] c, input logic [1:0] inc);
    logic [16:0] s;
    s = {1'b0, c} + 17'(inc);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  logic [1:0] n_upd, n_mis;
  assign n_upd = {1'b0, upd_valid0_i} + {1'b0, upd_valid1_i};
  assign n_mis = {1'b0, mis0} + {1'b0, mis1};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      br_count_o      <= '0;
      mispred_count_o <= '0;
    end else if (busy_o) begin
      br_count_o      <= '0;
      mispred_count_o <= '0;
    end else begin
      br_count_o      <= sat_add(br_count_o, n_upd);
      mispred_count_o <= sat_add(mispred_count_o, n_mis);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_gshare_branch_predictor.sv
`default_nettype none
// Directed table-driven bench for gshare_branch_predictor (default build).
module tb_gshare_branch_predictor;

  logic       clk = 1'b0;
  logic       reset;
  logic       busy_o;
  logic       fetch_valid_i;
  logic [8:0] pc0_i, pc1_i;
  logic       pred_taken0_o, pred_taken1_o;
  logic [8:0] pred_target0_o, pred_target1_o;
  logic [5:0] pred_hist0_o, pred_hist1_o;
  logic       upd_valid0_i, upd_valid1_i;
  logic [8:0] upd_pc0_i, upd_pc1_i;
  logic [5:0] upd_hist0_i, upd_hist1_i;
  logic       upd_taken0_i, upd_taken1_i;
  logic [8:0] upd_target0_i, upd_target1_i;
  logic       upd_mispred0_i, upd_mispred1_i;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gshare_branch_predictor dut (
    .clk(clk), .reset(reset), .busy_o(busy_o), .fetch_valid_i(fetch_valid_i),
    .pc0_i(pc0_i), .pc1_i(pc1_i),
    .pred_taken0_o(pred_taken0_o), .pred_taken1_o(pred_taken1_o),
    .pred_target0_o(pred_target0_o), .pred_target1_o(pred_target1_o),
    .pred_hist0_o(pred_hist0_o), .pred_hist1_o(pred_hist1_o),
    .upd_valid0_i(upd_valid0_i), .upd_valid1_i(upd_valid1_i),
    .upd_pc0_i(upd_pc0_i), .upd_pc1_i(upd_pc1_i),
    .upd_hist0_i(upd_hist0_i), .upd_hist1_i(upd_hist1_i),
    .upd_taken0_i(upd_taken0_i), .upd_taken1_i(upd_taken1_i),
    .upd_target0_i(upd_target0_i), .upd_target1_i(upd_target1_i),
    .upd_mispred0_i(upd_mispred0_i), .upd_mispred1_i(upd_mispred1_i)
  );

  typedef struct {
    logic       fv;
    logic [8:0] pc0, pc1;
    logic       uv0, uv1;
    logic [8:0] upc0, upc1;
    logic [5:0] uh0, uh1;
    logic       ut0, ut1;
    logic [8:0] utg0, utg1;
    logic       um0, um1;
    logic       et0, et1;
    logic [8:0] etg0, etg1;
    logic [5:0] eh0, eh1;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t L(input logic fv, input logic [8:0] pc0, input logic [8:0] pc1,
                             input logic et0, input logic [8:0] etg0, input logic [5:0] eh0,
                             input logic et1, input logic [8:0] etg1, input logic [5:0] eh1);
    vec_t v;
    v = '{default: 0};
    v.fv = fv; v.pc0 = pc0; v.pc1 = pc1;
    v.et0 = et0; v.etg0 = etg0; v.eh0 = eh0;
    v.et1 = et1; v.etg1 = etg1; v.eh1 = eh1;
    return v;
  endfunction

  function automatic vec_t U(input vec_t b, input int lane, input logic [8:0] pc,
                             input logic [5:0] h, input logic t, input logic [8:0] tg,
                             input logic m);
    vec_t v;
    v = b;
    if (lane == 0) begin
      v.uv0 = 1'b1; v.upc0 = pc; v.uh0 = h; v.ut0 = t; v.utg0 = tg; v.um0 = m;
    end else begin
      v.uv1 = 1'b1; v.upc1 = pc; v.uh1 = h; v.ut1 = t; v.utg1 = tg; v.um1 = m;
    end
    return v;
  endfunction

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  task automatic idle();
    fetch_valid_i = 0; pc0_i = '0; pc1_i = '0;
    upd_valid0_i = 0; upd_valid1_i = 0; upd_pc0_i = '0; upd_pc1_i = '0;
    upd_hist0_i = '0; upd_hist1_i = '0; upd_taken0_i = 0; upd_taken1_i = 0;
    upd_target0_i = '0; upd_target1_i = '0; upd_mispred0_i = 0; upd_mispred1_i = 0;
  endtask

  // Runs from reset release until busy drops; checks the forced lookups each cycle
  task automatic busy_sweep(input logic inject, output int n);
    logic [8:0] e0, e1;
    n = 0;
    while (busy_o && n < 200) begin
      pc0_i = 9'h1FF - 9'(n);
      pc1_i = 9'(n * 5);
      if (inject && n == 40) begin
        upd_valid0_i = 1; upd_pc0_i = 9'h020; upd_hist0_i = 6'h3F;
        upd_taken0_i = 1; upd_target0_i = 9'h1AA; upd_mispred0_i = 1;
      end
      e0 = pc0_i + 9'd1;
      e1 = pc1_i + 9'd1;
      #1;
      chk("busy_lookup", n,
          {pred_taken0_o, pred_taken1_o, pred_hist0_o, pred_hist1_o, pred_target0_o, pred_target1_o},
          {2'b00, 12'h000, e0, e1});
      @(posedge clk); #1;
      n++;
      idle();
    end
  endtask

  initial begin
    int n;
    vec_t v;
    reset = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    chk("reset_busy", 0, 32'(busy_o), 32'd1);
    chk("reset_hist", 0, 32'(pred_hist0_o), 32'd0);

    // Deassert reset away from the clock edge
    reset = 1'b0;
    busy_sweep(1'b1, n);
    chk("busy_cycles", 0, n, 64);

    vecs.push_back(L(0, 9'h020, 9'h100, 0, 9'h021, 6'h00, 0, 9'h101, 6'h00));
    vecs.push_back(U(L(0, 9'h012, 9'h100, 0, 9'h013, 6'h00, 0, 9'h101, 6'h00), 0, 9'h012, 6'h00, 1, 9'h040, 0));
    vecs.push_back(U(L(0, 9'h012, 9'h100, 1, 9'h040, 6'h00, 0, 9'h101, 6'h01), 0, 9'h012, 6'h00, 1, 9'h040, 0));
    vecs.push_back(L(0, 9'h012, 9'h100, 1, 9'h040, 6'h00, 0, 9'h101, 6'h01));
    vecs.push_back(U(U(L(0, 9'h007, 9'h100, 0, 9'h008, 6'h00, 0, 9'h101, 6'h00), 0, 9'h007, 6'h00, 1, 9'h100, 0),
                     1, 9'h007, 6'h00, 0, 9'h1FF, 0));
    vecs.push_back(L(0, 9'h007, 9'h100, 0, 9'h008, 6'h00, 0, 9'h101, 6'h00));
    vecs.push_back(U(L(0, 9'h007, 9'h100, 0, 9'h008, 6'h00, 0, 9'h101, 6'h00), 0, 9'h007, 6'h00, 1, 9'h100, 0));
    vecs.push_back(L(0, 9'h007, 9'h100, 1, 9'h100, 6'h00, 0, 9'h101, 6'h01));
    vecs.push_back(U(L(0, 9'h100, 9'h100, 0, 9'h101, 6'h00, 0, 9'h101, 6'h00), 0, 9'h031, 6'h01, 1, 9'h077, 0));
    vecs.push_back(U(L(0, 9'h100, 9'h100, 0, 9'h101, 6'h00, 0, 9'h101, 6'h00), 0, 9'h031, 6'h01, 1, 9'h077, 0));
    // Lane 0 taken squashes a lane 1 that would otherwise be taken
    vecs.push_back(L(1, 9'h012, 9'h031, 1, 9'h040, 6'h00, 0, 9'h032, 6'h01));
    vecs.push_back(L(0, 9'h100, 9'h100, 0, 9'h101, 6'h01, 0, 9'h101, 6'h01));
    vecs.push_back(L(1, 9'h007, 9'h031, 0, 9'h008, 6'h01, 0, 9'h032, 6'h02));
    vecs.push_back(L(0, 9'h100, 9'h100, 0, 9'h101, 6'h04, 0, 9'h101, 6'h04));
    vecs.push_back(U(L(0, 9'h100, 9'h100, 0, 9'h101, 6'h04, 0, 9'h101, 6'h04), 0, 9'h03F, 6'h16, 1, 9'h000, 1));
    vecs.push_back(L(0, 9'h100, 9'h100, 0, 9'h101, 6'h2D, 0, 9'h101, 6'h2D));
    // Lane 0 repair wins over lane 1 repair and the concurrent fetch shift
    vecs.push_back(U(U(L(1, 9'h012, 9'h100, 0, 9'h013, 6'h2D, 0, 9'h101, 6'h1A), 0, 9'h03E, 6'h03, 0, 9'h000, 1),
                     1, 9'h010, 6'h3F, 1, 9'h0AA, 1));
    vecs.push_back(L(0, 9'h100, 9'h100, 0, 9'h101, 6'h06, 0, 9'h101, 6'h06));
    vecs.push_back(U(U(L(0, 9'h100, 9'h100, 0, 9'h101, 6'h06, 0, 9'h101, 6'h06), 0, 9'h02A, 6'h00, 0, 9'h000, 0),
                     1, 9'h011, 6'h05, 1, 9'h0BB, 1));
    vecs.push_back(L(0, 9'h100, 9'h100, 0, 9'h101, 6'h0B, 0, 9'h101, 6'h0B));
    vecs.push_back(U(U(L(0, 9'h100, 9'h100, 0, 9'h101, 6'h0B, 0, 9'h101, 6'h0B), 0, 9'h005, 6'h00, 1, 9'h0CC, 0),
                     1, 9'h03C, 6'h00, 0, 9'h000, 1));
    vecs.push_back(U(L(0, 9'h100, 9'h100, 0, 9'h101, 6'h00, 0, 9'h101, 6'h00), 0, 9'h005, 6'h00, 1, 9'h0CC, 0));
    vecs.push_back(L(0, 9'h005, 9'h100, 1, 9'h0CC, 6'h00, 0, 9'h101, 6'h01));
    // Tag alias misses; lane 1 hit is not squashed
    vecs.push_back(L(0, 9'h045, 9'h005, 0, 9'h046, 6'h00, 1, 9'h0CC, 6'h00));
    vecs.push_back(U(L(0, 9'h100, 9'h100, 0, 9'h101, 6'h00, 0, 9'h101, 6'h00), 0, 9'h005, 6'h00, 0, 9'h000, 0));
    vecs.push_back(L(0, 9'h005, 9'h100, 1, 9'h0CC, 6'h00, 0, 9'h101, 6'h01));
    vecs.push_back(U(U(L(0, 9'h100, 9'h100, 0, 9'h101, 6'h00, 0, 9'h101, 6'h00), 0, 9'h028, 6'h00, 1, 9'h111, 0),
                     1, 9'h028, 6'h00, 1, 9'h122, 0));
    vecs.push_back(L(0, 9'h028, 9'h100, 1, 9'h122, 6'h00, 0, 9'h101, 6'h01));
    vecs.push_back(U(U(L(0, 9'h100, 9'h100, 0, 9'h101, 6'h00, 0, 9'h101, 6'h00), 0, 9'h028, 6'h00, 0, 9'h000, 0),
                     1, 9'h028, 6'h00, 0, 9'h000, 0));
    vecs.push_back(L(0, 9'h028, 9'h100, 0, 9'h029, 6'h00, 0, 9'h101, 6'h00));
    vecs.push_back(L(0, 9'h1FF, 9'h1FF, 0, 9'h000, 6'h00, 0, 9'h000, 6'h00));

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      @(negedge clk);
      fetch_valid_i = v.fv; pc0_i = v.pc0; pc1_i = v.pc1;
      upd_valid0_i = v.uv0; upd_pc0_i = v.upc0; upd_hist0_i = v.uh0; upd_taken0_i = v.ut0;
      upd_target0_i = v.utg0; upd_mispred0_i = v.um0;
      upd_valid1_i = v.uv1; upd_pc1_i = v.upc1; upd_hist1_i = v.uh1; upd_taken1_i = v.ut1;
      upd_target1_i = v.utg1; upd_mispred1_i = v.um1;
      #1;
      chk("taken0", i, 32'(pred_taken0_o), 32'(v.et0));
      chk("target0", i, 32'(pred_target0_o), 32'(v.etg0));
      chk("hist0", i, 32'(pred_hist0_o), 32'(v.eh0));
      chk("taken1", i, 32'(pred_taken1_o), 32'(v.et1));
      chk("target1", i, 32'(pred_target1_o), 32'(v.etg1));
      chk("hist1", i, 32'(pred_hist1_o), 32'(v.eh1));
    end

    // Reset in the middle of a sweep restarts it from entry 0
    @(negedge clk); idle(); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("midsweep_busy", 0, 32'(busy_o), 32'd1);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    busy_sweep(1'b0, n);
    chk("restart_cycles", 0, n, 64);
    @(negedge clk);
    pc0_i = 9'h012;
    #1;
    chk("swept_taken", 0, 32'(pred_taken0_o), 32'd0);
    chk("swept_target", 0, 32'(pred_target0_o), 32'h013);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
